// File: rtl/uart_rx_packer.sv
// uart_rx_packer: UART receiver that packs consecutive bytes into one wide
// packet (matrix K in the low bits, vector X above it) and hands it to a
// downstream engine over a valid/ready interface.
//
// Optional build macro: UART_RX_SYNC_EN. When it is defined, rx goes through a
// 2-flop synchronizer that resets to 1, which adds 2 cycles of latency. When it
// is undefined, rx is sampled directly.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   rx        in   UART serial line, idle high
//   m_data    out  packed packet, W_PKT bits (K low, X high)
//   m_valid   out  m_data holds a complete packet
//   m_ready   in   downstream accepts the packet
//   frame_err out  one-cycle pulse after a bad stop bit
//   overflow  out  one-cycle pulse when a packet is dropped
//   busy      out  receive FSM is not idle
module uart_rx_packer #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int R                = 4,
  parameter int C                = 4,
  parameter int W_X              = 4,
  parameter int W_K              = 2,
  localparam int W_PKT   = R*C*W_K + C*W_X,
  localparam int N_WORDS = (W_PKT + BITS_PER_WORD - 1) / BITS_PER_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [W_PKT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overflow,
  output logic             busy
);

  localparam int W_BUF = N_WORDS * BITS_PER_WORD;
  localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int WC_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BIT_W-1:0]         bit_idx_q, bit_idx_d;
  logic [BITS_PER_WORD-1:0] shift_q, shift_d;
  logic [W_BUF-1:0]         pack_q, pack_d;
  logic [WC_W-1:0]          word_cnt_q, word_cnt_d;
  logic [W_PKT-1:0]         m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overflow_q, overflow_d;
  logic                     busy_q, busy_d;
  logic                     rx_s;
  logic                     sample_s;
  logic                     accept_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      pack_q      <= '0;
      word_cnt_q  <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      pack_q      <= pack_d;
      word_cnt_q  <= word_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  // Receive FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
        else       state_d = IDLE;
      end
      START: begin
        // Mid-start-bit check: a high line here was only a glitch.
        if (cnt_q == HALF_LAST) state_d = rx_s ? IDLE : DATA;
        else                    state_d = START;
      end
      DATA: begin
        if (cnt_q == FULL_LAST && bit_idx_q == BIT_LAST) state_d = STOP;
        else                                             state_d = DATA;
      end
      STOP: begin
        if (cnt_q == FULL_LAST) state_d = IDLE;
        else                    state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing, byte assembly, packing and output handshake.
  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    pack_d      = pack_q;
    word_cnt_d  = word_cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    busy_d      = (state_d != IDLE);

    case (state_q)
      START:   sample_s = (cnt_q == HALF_LAST);
      DATA:    sample_s = (cnt_q == FULL_LAST);
      STOP:    sample_s = (cnt_q == FULL_LAST);
      default: sample_s = 1'b0;
    endcase

    if (state_q == IDLE) begin
      cnt_d     = '0;
      bit_idx_d = '0;
    end else if (sample_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_q == DATA && sample_s) begin
      // LSB first: each new bit enters at the top and shifts down.
      shift_d = shift_q >> 1;
      shift_d[BITS_PER_WORD-1] = rx_s;
      bit_idx_d = bit_idx_q + BIT_W'(1);
    end else begin
      shift_d = shift_q;
    end

    accept_s    = (state_q == STOP) && sample_s && rx_s;
    frame_err_d = (state_q == STOP) && sample_s && !rx_s;

    // A consumed packet drops valid unless a new one is loaded below.
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    else                      m_valid_d = m_valid_q;

    if (accept_s) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (word_cnt_q == WC_W'(i)) pack_d[i*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
      end
      if (word_cnt_q == WORD_LAST) begin
        word_cnt_d = '0;
        // Output slot is free, or being emptied this very cycle.
        if (!m_valid_q || m_ready) begin
          m_data_d  = pack_d[W_PKT-1:0];
          m_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        word_cnt_d = word_cnt_q + WC_W'(1);
      end
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
module tb_uart_rx_packer;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Negedges from driving the last stop bit to seeing m_valid high.
  localparam int EXP_LAT = 3 + SYNC_LAT;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [47:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        frame_err;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state, written only by the monitor process.
  logic        mon_clr = 1'b0;
  logic        prev_valid = 1'b0;
  int          vrise = 0;
  int          ovf_cnt = 0;
  int          ferr_cnt = 0;
  int          busy_seen = 0;
  logic [47:0] vdata = 48'h0;

  int          lat;

  uart_rx_packer dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count output events between clears, sampling away from the active edge.
  always @(negedge clk) begin
    if (mon_clr) begin
      vrise     <= 0;
      ovf_cnt   <= 0;
      ferr_cnt  <= 0;
      busy_seen <= 0;
      vdata     <= 48'h0;
    end else begin
      if (m_valid && !prev_valid) begin
        vrise <= vrise + 1;
        vdata <= m_data;
      end
      if (overflow)  ovf_cnt   <= ovf_cnt + 1;
      if (frame_err) ferr_cnt  <= ferr_cnt + 1;
      if (busy)      busy_seen <= busy_seen + 1;
    end
    prev_valid <= m_valid;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    @(posedge clk);
    mon_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b0;
  endtask

  // One UART frame, 4 clocks per bit, then 5 idle cycles. Reports how many
  // negedges after the stop bit m_valid was first seen high (-1 if never).
  // With rdy_stop, m_ready is pulsed exactly over the stop-bit sample edge.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic rdy_stop,
                           output int lat_o);
    lat_o = -1;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rx = b[k];
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    rx = stop;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) rx = 1'b1;
      if (rdy_stop && i == 2 + SYNC_LAT) m_ready = 1'b1;
      if (rdy_stop && i == 3 + SYNC_LAT) m_ready = 1'b0;
      if (lat_o < 0 && m_valid) lat_o = i;
    end
  endtask

  task automatic send_seq(input logic [7:0] first, input int n);
    int l;
    for (int k = 0; k < n; k++) send_byte(first + 8'(k), 1'b1, 1'b0, l);
  endtask

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_m_data", m_data, 48'h0);
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic packet with the consumer always ready.
    m_ready = 1'b1;
    clr_mon();
    send_seq(8'h01, 5);
    send_byte(8'h06, 1'b1, 1'b0, lat);
    check_eq("pkt_vrise", vrise, 1);
    check_eq("pkt_data", vdata, 48'h060504030201);
    check_eq("pkt_latency", lat, EXP_LAT);
    check_eq("pkt_ovf", ovf_cnt, 0);
    check_eq("pkt_ferr", ferr_cnt, 0);
    check_eq("pkt_valid_drop", m_valid, 1'b0);

    // Stalled consumer: second packet is dropped.
    m_ready = 1'b0;
    clr_mon();
    send_seq(8'h01, 6);
    check_eq("stall_valid", m_valid, 1'b1);
    send_seq(8'hA1, 6);
    check_eq("stall_ovf", ovf_cnt, 1);
    check_eq("stall_data", m_data, 48'h060504030201);
    check_eq("stall_vrise", vrise, 1);
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_eq("stall_drain", m_valid, 1'b0);

    // Consume and reload in the same cycle: no overflow, valid stays high.
    clr_mon();
    send_seq(8'hB1, 6);
    check_eq("swap_first", m_data, 48'hB6B5B4B3B2B1);
    send_seq(8'hC1, 5);
    send_byte(8'hC6, 1'b1, 1'b1, lat);
    check_eq("swap_valid", m_valid, 1'b1);
    check_eq("swap_data", m_data, 48'hC6C5C4C3C2C1);
    check_eq("swap_ovf", ovf_cnt, 0);
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);

    // Bad stop bit discards that byte only.
    clr_mon();
    send_byte(8'h55, 1'b0, 1'b0, lat);
    send_seq(8'h10, 6);
    check_eq("ferr_cnt", ferr_cnt, 1);
    check_eq("ferr_vrise", vrise, 1);
    check_eq("ferr_data", vdata, 48'h151413121110);
    check_eq("ferr_ovf", ovf_cnt, 0);

    // One-cycle low glitch at idle.
    clr_mon();
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("glitch_busy_seen", busy_seen != 0, 1'b1);
    check_eq("glitch_busy_end", busy, 1'b0);
    check_eq("glitch_ferr", ferr_cnt, 0);
    clr_mon();
    send_seq(8'h30, 6);
    check_eq("glitch_vrise", vrise, 1);
    check_eq("glitch_data", vdata, 48'h353433323130);

    // Reset mid-packet discards partial words.
    send_seq(8'h77, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_valid", m_valid, 1'b0);
    @(negedge clk);
    check_eq("mrst_busy", busy, 1'b0);
    rst = 1'b0;
    clr_mon();
    send_seq(8'h20, 6);
    check_eq("mrst_vrise", vrise, 1);
    check_eq("mrst_data", vdata, 48'h252423222120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
